// File: rtl/plab4_net_router_pkg.sv
// rtl/plab4_net_router_pkg.sv - shared router constants: port indices and widths
//
// Contents:
//   WEST/TERM/EAST  input port indices 0/1/2
//   c_num_ports     number of router input ports (3)
//   c_num_domains   number of security domains (2)
//   c_sel_nbits     width of a crossbar select / port index (2)

package plab4_net_router_pkg;

  localparam int c_num_ports   = 3;
  localparam int c_num_domains = 2;
  localparam int c_sel_nbits   = 2;

  localparam logic [c_sel_nbits-1:0] WEST = 2'd0;
  localparam logic [c_sel_nbits-1:0] TERM = 2'd1;
  localparam logic [c_sel_nbits-1:0] EAST = 2'd2;

endpackage

// File: rtl/plab4_net_rr_arb3.sv
// rtl/plab4_net_rr_arb3.sv - combinational 3-input round-robin picker
//
// Ports:
//   reqs   in  3  request vector, bit i = input i wants the output
//   prio   in  2  index of highest-priority input (3 decodes as 0)
//   en     in  1  grant enable; when low no grant is issued
//   grants out 3  one-hot grant, zero when disabled or no request
//   gidx   out 2  index of the granted input, zero when no grant

module plab4_net_rr_arb3
  import plab4_net_router_pkg::*;
(
  input  logic [c_num_ports-1:0] reqs,
  input  logic [c_sel_nbits-1:0] prio,
  input  logic                   en,
  output logic [c_num_ports-1:0] grants,
  output logic [c_sel_nbits-1:0] gidx
);

  logic [c_sel_nbits-1:0] start;
  logic [2:0]             cand;
  logic                   found;

  always_comb begin
    // Out-of-range pointer value 3 is treated as WEST.
    case (prio)
      TERM:    start = TERM;
      EAST:    start = EAST;
      default: start = WEST;
    endcase

    grants = '0;
    gidx   = '0;
    found  = 1'b0;
    cand   = '0;
    // Scan start, start+1, start+2 (mod 3); first requester wins.
    for (int k = 0; k < c_num_ports; k++) begin
      cand = {1'b0, start} + k[2:0];
      if (cand >= 3'd3) cand = cand - 3'd3;
      if (en && !found && reqs[cand[1:0]]) begin
        grants[cand[1:0]] = 1'b1;
        gidx              = cand[1:0];
        found             = 1'b1;
      end
    end
  end

endmodule

// File: rtl/plab4_net_router_output_ctrl.sv
// rtl/plab4_net_router_output_ctrl.sv - per-output-port grant control with per-domain round-robin
//
// Optional feature macro: PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN (per-domain saturating stats counters)
//
// Ports:
//   clk       in  1  clock
//   reset     in  1  asynchronous active-high reset
//   cur_sd    in  1  current security domain
//   reqs      in  3  request from each input port
//   grants    out 3  one-hot grant back to the input ports
//   sel       out 2  crossbar select = index of granted input
//   out_val   out 1  flit presented on this output
//   out_rdy   in  1  downstream can accept
//   gnt_cnt0/1/2 out p_cnt_nbits  transfers per input, cur_sd copy (stats build only)
//   stall_cnt    out p_cnt_nbits  cycles with requests but !out_rdy, cur_sd copy (stats build only)

module plab4_net_router_output_ctrl
  import plab4_net_router_pkg::*;
#(
  parameter int p_router_id = 0,
  parameter int p_cnt_nbits = 16
)(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cur_sd,
  input  logic [c_num_ports-1:0] reqs,
  output logic [c_num_ports-1:0] grants,
  output logic [c_sel_nbits-1:0] sel,
  output logic                   out_val,
  input  logic                   out_rdy
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  ,
  output logic [p_cnt_nbits-1:0] gnt_cnt0,
  output logic [p_cnt_nbits-1:0] gnt_cnt1,
  output logic [p_cnt_nbits-1:0] gnt_cnt2,
  output logic [p_cnt_nbits-1:0] stall_cnt
`endif
);

  logic [c_sel_nbits-1:0] prio [c_num_domains];
  logic [c_sel_nbits-1:0] gidx;
  logic [c_sel_nbits-1:0] next_prio;
  logic                   arb_en;
  logic [31:0]            unused_params;

  // Grants are forced low for the whole time reset is high, not just at edges.
  assign arb_en = out_rdy & ~reset;

  plab4_net_rr_arb3 u_arb (
    .reqs   (reqs),
    .prio   (prio[cur_sd]),
    .en     (arb_en),
    .grants (grants),
    .gidx   (gidx)
  );

  assign out_val   = |grants;
  assign sel       = gidx;
  assign next_prio = (gidx == EAST) ? WEST : gidx + 2'd1;

  // Only the active domain's pointer moves, and only on a transfer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < c_num_domains; d++) prio[d] <= WEST;
    end else if (out_val) begin
      prio[cur_sd] <= next_prio;
    end
  end

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  localparam logic [p_cnt_nbits-1:0] c_cnt_max = '1;
  localparam logic [p_cnt_nbits-1:0] c_cnt_one = 1;

  logic [p_cnt_nbits-1:0] gnt_cnt_r   [c_num_domains][c_num_ports];
  logic [p_cnt_nbits-1:0] stall_cnt_r [c_num_domains];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int d = 0; d < c_num_domains; d++) begin
        stall_cnt_r[d] <= '0;
        for (int i = 0; i < c_num_ports; i++) gnt_cnt_r[d][i] <= '0;
      end
    end else begin
      for (int i = 0; i < c_num_ports; i++) begin
        if (grants[i] && gnt_cnt_r[cur_sd][i] != c_cnt_max)
          gnt_cnt_r[cur_sd][i] <= gnt_cnt_r[cur_sd][i] + c_cnt_one;
      end
      if ((|reqs) && !out_rdy && stall_cnt_r[cur_sd] != c_cnt_max)
        stall_cnt_r[cur_sd] <= stall_cnt_r[cur_sd] + c_cnt_one;
    end
  end

  assign gnt_cnt0  = gnt_cnt_r[cur_sd][WEST];
  assign gnt_cnt1  = gnt_cnt_r[cur_sd][TERM];
  assign gnt_cnt2  = gnt_cnt_r[cur_sd][EAST];
  assign stall_cnt = stall_cnt_r[cur_sd];

  // Router id is a tag for debug/stats tooling only; no logic depends on it.
  assign unused_params = 32'(p_router_id);
`else
  assign unused_params = 32'(p_router_id) ^ 32'(p_cnt_nbits);
`endif

endmodule

// File: tb/tb_plab4_net_router_output_ctrl.sv
// tb/tb_plab4_net_router_output_ctrl.sv - scoreboard bench for the router output control

module tb_plab4_net_router_output_ctrl;

  typedef struct {
    logic [2:0] g;
    logic [1:0] s;
    logic       v;
    string      name;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       cur_sd;
  logic [2:0] reqs;
  logic [2:0] grants;
  logic [1:0] sel;
  logic       out_val;
  logic       out_rdy;
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
  logic [1:0] gnt_cnt0, gnt_cnt1, gnt_cnt2, stall_cnt;
`endif

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t exp_q[$];

  plab4_net_router_output_ctrl #(.p_router_id(0), .p_cnt_nbits(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .cur_sd    (cur_sd),
    .reqs      (reqs),
    .grants    (grants),
    .sel       (sel),
    .out_val   (out_val),
    .out_rdy   (out_rdy)
`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    ,
    .gnt_cnt0  (gnt_cnt0),
    .gnt_cnt1  (gnt_cnt1),
    .gnt_cnt2  (gnt_cnt2),
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Expected select is the bench's own decode of the hand-computed one-hot grant.
  function automatic logic [1:0] sel_of(input logic [2:0] g);
    case (g)
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  task automatic expect_now(input logic [2:0] g, input string nm);
    exp_t e;
    e.g = g; e.s = sel_of(g); e.v = |g; e.name = nm;
    exp_q.push_back(e);
  endtask

  // Called at posedge+1: apply inputs, queue expectation, advance one cycle.
  task automatic step(input logic [2:0] r, input logic rdy, input logic sd,
                      input logic [2:0] g, input string nm);
    reqs = r; out_rdy = rdy; cur_sd = sd;
    expect_now(g, nm);
    @(posedge clk); #1;
  endtask

  // Monitor: compare DUT outputs mid-cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, ".grants"},  32'(grants),  32'(e.g));
        check({e.name, ".sel"},     32'(sel),     32'(e.s));
        check({e.name, ".out_val"}, 32'(out_val), 32'(e.v));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; reqs = 3'b111; out_rdy = 1'b1; cur_sd = 1'b0;
    @(posedge clk); #1;
    // 1: held in reset with all requesting
    step(3'b111, 1'b1, 1'b0, 3'b000, "reset_hold");
    reset = 1'b0;

    // 2: rotation from prio=0
    step(3'b111, 1'b1, 1'b0, 3'b001, "rr_a");
    step(3'b111, 1'b1, 1'b0, 3'b010, "rr_b");
    step(3'b111, 1'b1, 1'b0, 3'b100, "rr_c");
    step(3'b111, 1'b1, 1'b0, 3'b001, "rr_d");       // prio0 -> 1

    // 3: stalls hold the pointer
    step(3'b110, 1'b0, 1'b0, 3'b000, "stall_a");
    step(3'b110, 1'b0, 1'b0, 3'b000, "stall_b");
    step(3'b110, 1'b0, 1'b0, 3'b000, "stall_c");
    step(3'b110, 1'b1, 1'b0, 3'b010, "unstall_a");
    step(3'b110, 1'b1, 1'b0, 3'b100, "unstall_b");  // prio0 -> 0
    step(3'b000, 1'b1, 1'b0, 3'b000, "no_reqs");

    // 4: domain isolation
    step(3'b111, 1'b1, 1'b0, 3'b001, "dom0_a");
    step(3'b111, 1'b1, 1'b0, 3'b010, "dom0_b");     // prio0 -> 2
    step(3'b111, 1'b1, 1'b1, 3'b001, "dom1_a");     // prio1 -> 1
    step(3'b111, 1'b1, 1'b0, 3'b100, "dom0_c");     // prio0 -> 0
    step(3'b111, 1'b1, 1'b1, 3'b010, "dom1_b");     // prio1 -> 2
    step(3'b111, 1'b1, 1'b0, 3'b001, "dom0_d");     // prio0 -> 1
    step(3'b101, 1'b1, 1'b0, 3'b100, "dom0_skip");  // prio0 -> 0
    step(3'b111, 1'b1, 1'b0, 3'b001, "dom0_e");     // prio0 -> 1

    // 5: async reset between edges during a transfer
    reqs = 3'b111; out_rdy = 1'b1; cur_sd = 1'b0;
    expect_now(3'b000, "async_reset");
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    step(3'b111, 1'b1, 1'b0, 3'b001, "post_reset_dom0");
    step(3'b111, 1'b1, 1'b1, 3'b001, "post_reset_dom1");

`ifdef PLAB4_NET_ROUTER_OUTPUT_CTRL_STATS_EN
    // 6: saturating counters (2-bit)
    reset = 1'b1; @(posedge clk); #1; reset = 1'b0;
    for (int i = 0; i < 5; i++) step(3'b010, 1'b1, 1'b0, 3'b010, "stats_xfer");
    step(3'b010, 1'b0, 1'b0, 3'b000, "stats_stall_a");
    step(3'b010, 1'b0, 1'b0, 3'b000, "stats_stall_b");
    reqs = 3'b000;
    check("gnt_cnt1_sat", 32'(gnt_cnt1), 32'd3);
    check("stall_cnt",    32'(stall_cnt), 32'd2);
    check("gnt_cnt0",     32'(gnt_cnt0), 32'd0);
    cur_sd = 1'b1; #1;
    check("gnt_cnt1_dom1",  32'(gnt_cnt1), 32'd0);
    check("stall_cnt_dom1", 32'(stall_cnt), 32'd0);
    cur_sd = 1'b0;
`endif

    reqs = 3'b000;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) check("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
